// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep checker.
package gate_sweep_pkg;

    // Width of the stimulus vector {first, second, third}
    localparam int VEC_W = 3;

    // Expected-function encodings for GATE_SEL
    localparam logic [1:0] GATE_NAND3 = 2'd0;
    localparam logic [1:0] GATE_AND3  = 2'd1;
    localparam logic [1:0] GATE_NOR3  = 2'd2;
    localparam logic [1:0] GATE_OR3   = 2'd3;

    // Largest possible error count: one per vector
    localparam logic [3:0] MAX_ERR = 4'd8;

    // Final vector of a sweep
    localparam logic [VEC_W-1:0] LAST_VECTOR = '1;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational model of the 3-input gate selected by GATE_SEL.
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter logic [1:0] GATE_SEL = GATE_NAND3
) (
    input  logic [VEC_W-1:0] vector,
    output logic             expected
);

    logic and_all;
    logic or_any;

    assign and_all = &vector;
    assign or_any  = |vector;

    // Select the reference function for the current vector
    always_comb begin
        expected = 1'b0;
        case (GATE_SEL)
            GATE_NAND3: expected = ~and_all;
            GATE_AND3:  expected = and_all;
            GATE_NOR3:  expected = ~or_any;
            GATE_OR3:   expected = or_any;
            default:    expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep checker for a 3-input gate: drives all eight input
// vectors in ascending order, lets each one settle, samples the gate output
// and counts mismatches against the reference function.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [1:0] GATE_SEL      = 2'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       gate_out,
    output logic       first,
    output logic       second,
    output logic       third,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_vector
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t           state_reg,       state_next;
    logic [VEC_W-1:0] vector_reg,      vector_next;
    logic [3:0]       settle_cnt_reg,  settle_cnt_next;
    logic [3:0]       err_count_reg,   err_count_next;
    logic [VEC_W-1:0] fail_vector_reg, fail_vector_next;

    logic expected_out;
    logic mismatch;

    gate_ref_model #(
        .GATE_SEL (GATE_SEL)
    ) u_ref (
        .vector   (vector_reg),
        .expected (expected_out)
    );

    assign mismatch = (gate_out != expected_out);

    // State and datapath registers; reset forces IDLE with everything cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            vector_reg      <= '0;
            settle_cnt_reg  <= '0;
            err_count_reg   <= '0;
            fail_vector_reg <= '0;
        end else begin
            state_reg       <= state_next;
            vector_reg      <= vector_next;
            settle_cnt_reg  <= settle_cnt_next;
            err_count_reg   <= err_count_next;
            fail_vector_reg <= fail_vector_next;
        end
    end

    // Next-state and datapath update. The settle counter is cleared to 0 on
    // start but reloaded with 1 between vectors, so the first vector also
    // absorbs the load cycle: total sweep is 1 + 8*(SETTLE_CYCLES+1) cycles.
    always_comb begin
        state_next       = state_reg;
        vector_next      = vector_reg;
        settle_cnt_next  = settle_cnt_reg;
        err_count_next   = err_count_reg;
        fail_vector_next = fail_vector_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next       = ST_SETTLE;
                    vector_next      = '0;
                    settle_cnt_next  = '0;
                    err_count_next   = '0;
                    fail_vector_next = '0;
                end
            end

            ST_SETTLE: begin
                if (settle_cnt_reg >= SETTLE_LAST) begin
                    state_next = ST_CHECK;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 4'd1;
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    if (err_count_reg < MAX_ERR) begin
                        err_count_next = err_count_reg + 4'd1;
                    end
                    if (err_count_reg == 4'd0) begin
                        fail_vector_next = vector_reg;
                    end
                end
                if (vector_reg == LAST_VECTOR) begin
                    state_next = ST_DONE;
                end else begin
                    state_next      = ST_SETTLE;
                    vector_next     = vector_reg + 1'b1;
                    settle_cnt_next = 4'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The gate inputs are the vector register itself, so they change on the
    // same edge as the vector and hold 111 once the sweep completes.
    assign first       = vector_reg[2];
    assign second      = vector_reg[1];
    assign third       = vector_reg[0];
    assign busy        = (state_reg == ST_SETTLE) || (state_reg == ST_CHECK);
    assign done        = (state_reg == ST_DONE);
    assign pass        = done && (err_count_reg == 4'd0);
    assign err_count   = err_count_reg;
    assign fail_vector = fail_vector_reg;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench: four checkers (one per gate function, different settle
// times) each driving a bench-side gate whose truth table is chosen per test.
module tb_gate_sweep_checker;

    localparam int N     = 4;
    localparam int M_END = 45;

    logic             clk;
    logic             reset;
    logic [N-1:0]     start_v;
    logic [N-1:0]     gate_out_v;
    logic [N-1:0]     first_v, second_v, third_v;
    logic [N-1:0]     busy_v, done_v, pass_v;
    logic [3:0]       err_v  [N];
    logic [2:0]       fail_v [N];
    logic [7:0]       tt_v   [N];

    int tests_run = 0;
    int failed    = 0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            gate_sweep_checker #(
                .SETTLE_CYCLES ((gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 3 : 4),
                .GATE_SEL      (2'(gi))
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .start       (start_v[gi]),
                .gate_out    (gate_out_v[gi]),
                .first       (first_v[gi]),
                .second      (second_v[gi]),
                .third       (third_v[gi]),
                .busy        (busy_v[gi]),
                .done        (done_v[gi]),
                .pass        (pass_v[gi]),
                .err_count   (err_v[gi]),
                .fail_vector (fail_v[gi])
            );
            // Gate under test: arbitrary truth table indexed by {A,B,C}
            assign gate_out_v[gi] = tt_v[gi][{first_v[gi], second_v[gi], third_v[gi]}];
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int settle_of(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    // Gate functions by number: 0 NAND3, 1 AND3, 2 NOR3, 3 OR3
    function automatic bit ideal(int sel, int v);
        bit all_one  = (v == 7);
        bit any_one  = (v != 0);
        case (sel)
            0:       return !all_one;
            1:       return all_one;
            2:       return !any_one;
            default: return any_one;
        endcase
    endfunction

    function automatic logic [7:0] ideal_tt(int sel);
        logic [7:0] t = '0;
        for (int v = 0; v < 8; v++) t[v] = ideal(sel, v);
        return t;
    endfunction

    // Expected sweep outcome: count vectors where the gate disagrees
    task automatic expect_result(input int i, output int errs, output int fv);
        errs = 0;
        fv   = 0;
        for (int v = 0; v < 8; v++) begin
            if (tt_v[i][v] != ideal(i, v)) begin
                if (errs == 0) fv = v;
                errs++;
            end
        end
    endtask

    function automatic int vec_of(int i);
        return {first_v[i], second_v[i], third_v[i]};
    endfunction

    // Expected vector m cycles after the start edge
    function automatic int exp_vec(int i, int m);
        int s = settle_of(i);
        int v = (m <= 1) ? 0 : (m - 1) / (s + 1);
        return (v > 7) ? 7 : v;
    endfunction

    function automatic int latency_of(int i);
        return 1 + 8 * (settle_of(i) + 1);
    endfunction

    task automatic check(input string tag, input int idx, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_busy"}, i, busy_v[i], 0);
            check({tag, "_done"}, i, done_v[i], 0);
            check({tag, "_pass"}, i, pass_v[i], 0);
            check({tag, "_err"},  i, err_v[i],  0);
            check({tag, "_fail"}, i, fail_v[i], 0);
            check({tag, "_vec"},  i, vec_of(i), 0);
        end
    endtask

    // Pulse start on all checkers and follow the whole sweep cycle by cycle
    task automatic run_sweep(input string tag);
        int errs, fv, lat;
        start_v = '1;
        tick();
        start_v = '0;
        for (int m = 0; m <= M_END; m++) begin
            for (int i = 0; i < N; i++) begin
                lat = latency_of(i);
                check({tag, "_vec"},  i, vec_of(i), exp_vec(i, m));
                check({tag, "_busy"}, i, busy_v[i], (m < lat) ? 1 : 0);
                check({tag, "_done"}, i, done_v[i], (m >= lat) ? 1 : 0);
                if (m == M_END) begin
                    expect_result(i, errs, fv);
                    check({tag, "_err"},  i, err_v[i],  errs);
                    check({tag, "_fvec"}, i, fail_v[i], fv);
                    check({tag, "_pass"}, i, pass_v[i], (errs == 0) ? 1 : 0);
                end
            end
            if (m < M_END) tick();
        end
    endtask

    initial begin
        int found, lat0;
        reset   = 1'b1;
        start_v = '0;
        for (int i = 0; i < N; i++) tt_v[i] = ideal_tt(i);
        repeat (3) tick();
        reset = 1'b0;
        check_idle("reset");
        tick();
        check_idle("idle_hold");

        // Correct gates
        run_sweep("good");

        // Stuck-at faults and a fully inverted gate
        for (int i = 0; i < N; i++) tt_v[i] = 8'hFF;
        run_sweep("stuck1");
        for (int i = 0; i < N; i++) tt_v[i] = 8'h00;
        run_sweep("stuck0");
        for (int i = 0; i < N; i++) tt_v[i] = ~ideal_tt(i);
        run_sweep("inverted");
        // An AND3 gate checked against the NAND3 expectation
        tt_v[0] = ideal_tt(1);
        run_sweep("and_vs_nand");

        // Random faulty gates
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) tt_v[i] = 8'($urandom);
            run_sweep("random");
        end

        // Reset in the middle of a sweep, asserted together with start
        for (int i = 0; i < N; i++) tt_v[i] = 8'($urandom);
        start_v = '1;
        tick();
        start_v = '0;
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            if (vec_of(0) == 3) found = 1;
            else tick();
        end
        check("reach_011", 0, found, 1);
        reset   = 1'b1;
        start_v = '1;
        tick();
        reset   = 1'b0;
        start_v = '0;
        check_idle("mid_reset");
        tick();
        check_idle("post_reset_idle");
        run_sweep("after_reset");

        // Start held high: ignored while busy, restarts from DONE
        tt_v[0] = 8'hFF;
        lat0    = latency_of(0);
        start_v = 4'b0001;
        tick();
        for (int m = 0; m <= lat0; m++) begin
            check("hold_vec",  0, vec_of(0), exp_vec(0, m));
            check("hold_busy", 0, busy_v[0], (m < lat0) ? 1 : 0);
            check("hold_done", 0, done_v[0], (m >= lat0) ? 1 : 0);
            if (m < lat0) tick();
        end
        check("hold_err",  0, err_v[0],  1);
        check("hold_fvec", 0, fail_v[0], 7);
        check("hold_pass", 0, pass_v[0], 0);
        tick();
        check("restart_done", 0, done_v[0], 0);
        check("restart_busy", 0, busy_v[0], 1);
        check("restart_err",  0, err_v[0],  0);
        check("restart_fvec", 0, fail_v[0], 0);
        check("restart_vec",  0, vec_of(0), 0);
        start_v = '0;
        for (int m = 1; m <= lat0; m++) tick();
        check("rerun_done", 0, done_v[0], 1);
        check("rerun_err",  0, err_v[0],  1);
        check("rerun_fvec", 0, fail_v[0], 7);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
